// File: rtl/countdown_timer.sv
// MM:SS.cc countdown timer with 100 Hz decrement, BCD display output and timed alarm.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: pulse done/alarm at zero, reload preset and keep running.
module countdown_timer #(
    parameter int ALARM_TICKS = 300,
    parameter int ALARM_W     = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        load,
    input  logic [23:0] preset,
    output logic [23:0] digits,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t             state, state_n;
    logic [23:0]        digits_n, preset_q, preset_n;
    logic [ALARM_W-1:0] acnt, acnt_n;
    logic               alarm_n, done_n, running_n;
    logic               ss_q, press;

    // Clamp each nibble to the largest legal value for its digit position
    function automatic logic [23:0] saturate(input logic [23:0] p);
        logic [23:0] r;
        for (int unsigned i = 0; i < 6; i++) begin
            if (i == 3 || i == 5)
                r[i*4 +: 4] = (p[i*4 +: 4] > 4'd5) ? 4'd5 : p[i*4 +: 4];
            else
                r[i*4 +: 4] = (p[i*4 +: 4] > 4'd9) ? 4'd9 : p[i*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [23:0] bcd_dec(input logic [23:0] d);
        logic [23:0] r;
        logic        b;
        r = d;
        b = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (b) begin
                if (d[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = (i == 3 || i == 5) ? 4'd5 : 4'd9;
                end else begin
                    r[i*4 +: 4] = d[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign press = start_stop & ~ss_q;

    always_comb begin
        state_n  = state;
        digits_n = digits;
        preset_n = preset_q;
        acnt_n   = acnt;
        alarm_n  = alarm;
        done_n   = 1'b0;

        if (load && state != RUN) begin
            preset_n = saturate(preset);
            digits_n = saturate(preset);
            state_n  = IDLE;
            alarm_n  = 1'b0;
        end else if (press) begin
            case (state)
                IDLE:    if (digits != '0) state_n = RUN;
                RUN:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                DONE: begin
                    state_n  = IDLE;
                    digits_n = preset_q;
                    alarm_n  = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end else if (tick) begin
            if (state == RUN) begin
                if (digits == 24'h000001) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    digits_n = preset_q;
                    done_n   = 1'b1;
                    alarm_n  = 1'b1;
`else
                    digits_n = '0;
                    state_n  = DONE;
                    alarm_n  = 1'b1;
                    acnt_n   = '0;
`endif
                end else begin
                    digits_n = bcd_dec(digits);
                end
            end else if (state == DONE && alarm) begin
                if (acnt == ALARM_W'(ALARM_TICKS - 1))
                    alarm_n = 1'b0;
                else
                    acnt_n = acnt + 1'b1;
            end
        end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Alarm is only ever a single-clk pulse alongside done
        alarm_n = done_n;
`else
        done_n = (state_n == DONE);
`endif
        running_n = (state_n == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            digits   <= '0;
            preset_q <= '0;
            acnt     <= '0;
            alarm    <= 1'b0;
            done     <= 1'b0;
            running  <= 1'b0;
            ss_q     <= 1'b0;
        end else begin
            state    <= state_n;
            digits   <= digits_n;
            preset_q <= preset_n;
            acnt     <= acnt_n;
            alarm    <= alarm_n;
            done     <= done_n;
            running  <= running_n;
            ss_q     <= start_stop;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (default and COUNTDOWN_AUTO_RELOAD_EN builds).
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        load = 1'b0;
    logic [23:0] preset = '0;
    logic [23:0] digits;
    logic        running, done, alarm;

    int errors = 0;
    int checks = 0;

    countdown_timer #(.ALARM_TICKS(300), .ALARM_W(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_stop (start_stop),
        .load       (load),
        .preset     (preset),
        .digits     (digits),
        .running    (running),
        .done       (done),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic do_press();
        start_stop = 1'b1;
        cyc();
        start_stop = 1'b0;
        cyc();
    endtask

    task automatic do_load(input logic [23:0] p);
        preset = p;
        load   = 1'b1;
        cyc();
        load   = 1'b0;
    endtask

    initial begin
        #22 rst = 1'b1;
        cyc();
        chk("reset_digits", digits, 24'h0);
        chk("reset_running", {23'd0, running}, 24'd0);
        chk("reset_done", {23'd0, done}, 24'd0);
        chk("reset_alarm", {23'd0, alarm}, 24'd0);

        // 01:00.00 -> 00:59.99
        do_load(24'h010000);
        chk("load_digits", digits, 24'h010000);
        chk("load_idle", {23'd0, running}, 24'd0);
        do_press();
        chk("run_running", {23'd0, running}, 24'd1);
        do_tick(1);
        chk("dec_minute_borrow", digits, 24'h005999);

        // Async reset while running at 00:05.37
        do_press();
        do_load(24'h000537);
        do_press();
        chk("prerst_running", {23'd0, running}, 24'd1);
        #3 rst = 1'b0;
        #1;
        chk("async_digits", digits, 24'h0);
        chk("async_running", {23'd0, running}, 24'd0);
        chk("async_done", {23'd0, done}, 24'd0);
        chk("async_alarm", {23'd0, alarm}, 24'd0);
        #1 rst = 1'b1;
        cyc();
        do_press();
        chk("idle_zero_press", {23'd0, running}, 24'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        do_load(24'h000002);
        do_press();
        do_tick(2);
        chk("ar_done", {23'd0, done}, 24'd1);
        chk("ar_alarm", {23'd0, alarm}, 24'd1);
        chk("ar_digits", digits, 24'h000002);
        chk("ar_running", {23'd0, running}, 24'd1);
        cyc();
        chk("ar_done_fall", {23'd0, done}, 24'd0);
        chk("ar_alarm_fall", {23'd0, alarm}, 24'd0);
        do_tick(1);
        chk("ar_dec", digits, 24'h000001);
        chk("ar_no_done", {23'd0, done}, 24'd0);
        do_tick(1);
        chk("ar_done2", {23'd0, done}, 24'd1);
        chk("ar_digits2", digits, 24'h000002);
        do_press();
        chk("ar_pause", {23'd0, running}, 24'd0);
`else
        do_load(24'h000003);
        do_press();
        do_tick(2);
        chk("near_zero", digits, 24'h000001);
        chk("near_zero_done", {23'd0, done}, 24'd0);
        do_tick(1);
        chk("zero_digits", digits, 24'h0);
        chk("zero_done", {23'd0, done}, 24'd1);
        chk("zero_alarm", {23'd0, alarm}, 24'd1);
        chk("zero_running", {23'd0, running}, 24'd0);
        do_tick(299);
        chk("alarm_299", {23'd0, alarm}, 24'd1);
        do_tick(1);
        chk("alarm_300", {23'd0, alarm}, 24'd0);
        chk("done_held", {23'd0, done}, 24'd1);
        do_tick(2);
        chk("done_hold_digits", digits, 24'h0);
        do_press();
        chk("reload_digits", digits, 24'h000003);
        chk("reload_done", {23'd0, done}, 24'd0);
        chk("reload_running", {23'd0, running}, 24'd0);
        do_press();
        chk("idle_to_run", {23'd0, running}, 24'd1);
        do_press();
`endif

        // press beats tick in the same clk
        do_load(24'h001000);
        do_press();
        tick = 1'b1;
        start_stop = 1'b1;
        cyc();
        tick = 1'b0;
        start_stop = 1'b0;
        cyc();
        chk("press_tick_digits", digits, 24'h001000);
        chk("press_tick_pause", {23'd0, running}, 24'd0);
        do_tick(3);
        chk("pause_ignore_tick", digits, 24'h001000);
        do_press();
        chk("resume", {23'd0, running}, 24'd1);
        do_tick(1);
        chk("dec_sec_borrow", digits, 24'h000999);

        // load ignored in RUN, then saturation
        do_load(24'hFC97A9);
        chk("load_in_run", digits, 24'h000999);
        chk("load_in_run_state", {23'd0, running}, 24'd1);
        do_press();
        do_load(24'hFC97A9);
        chk("saturate", digits, 24'h595799);

        do_load(24'h100000);
        do_press();
        do_tick(1);
        chk("dec_full_borrow", digits, 24'h095999);
        do_press();

        // load and press together: load wins
        preset = 24'h000500;
        load = 1'b1;
        start_stop = 1'b1;
        cyc();
        load = 1'b0;
        start_stop = 1'b0;
        cyc();
        chk("load_beats_press", digits, 24'h000500);
        chk("load_beats_press_st", {23'd0, running}, 24'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
